// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller and instruction memory.
// The fetch controller is the master: it raises a request with an address
// and holds both until the memory answers with an ack and the data word.
interface if_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller.
// Issues one instruction-memory request at a time, holds the returned word
// for the fetch-stage register until it is consumed, and handles branch
// redirects. A redirect that arrives while a request is still outstanding
// cannot abandon that request, so the block drains it (dropping its data)
// before fetching from the branch target.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  if_fetch_ctrl_if.master       imem,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_addr,
  output logic [31:0]           pc_out,
  output logic [31:0]           instr_out,
  output logic                  instr_valid,
  output logic                  flush_out
);

  // FETCH : request outstanding, result will be kept
  // HOLD  : word held for the fetch-stage register, no request
  // DRAIN : request outstanding, result will be dropped (redirect pending)
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] next_pc;
  logic [31:0] branch_target;
  logic [31:0] fetch_next;
  logic        unused_branch_low;

  // Instructions are word aligned, so the low target bits carry no meaning.
  assign branch_target     = {branch_addr[31:2], 2'b00};
  assign unused_branch_low = ^branch_addr[1:0];

  // Wraps modulo 2^32, so the word after 32'hFFFF_FFFC is address zero.
  assign fetch_next = req_addr + 32'd4;

  // The request is a decode of the state register, forced low while reset
  // is asserted. Gating with rst lets the request appear as soon as reset is
  // released, so the first clock edge afterwards already sees it, and drops
  // it immediately when reset is asserted mid-transaction.
  assign imem.imem_req  = rst & (state != HOLD);
  assign imem.imem_addr = req_addr;

  // The fetch-stage register is flushed in the very cycle of the redirect.
  assign flush_out = branch_taken;

  // Fetch sequencing: state, request address, next PC and the held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      req_addr    <= RESET_PC;
      next_pc     <= RESET_PC;
      instr_out   <= 32'h0;
      pc_out      <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            next_pc <= branch_target;
            if (imem.imem_ack) begin
              req_addr <= branch_target;
            end else begin
              state <= DRAIN;
            end
          end else if (imem.imem_ack) begin
            instr_out   <= imem.imem_rdata;
            pc_out      <= fetch_next;
            next_pc     <= fetch_next;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (branch_taken) begin
            instr_out   <= 32'h0;
            pc_out      <= 32'h0;
            instr_valid <= 1'b0;
            req_addr    <= branch_target;
            next_pc     <= branch_target;
            state       <= FETCH;
          end else if (!freeze) begin
            instr_out   <= 32'h0;
            pc_out      <= 32'h0;
            instr_valid <= 1'b0;
            req_addr    <= next_pc;
            state       <= FETCH;
          end
        end

        DRAIN: begin
          if (imem.imem_ack) begin
            if (branch_taken) begin
              req_addr <= branch_target;
              next_pc  <= branch_target;
            end else begin
              req_addr <= next_pc;
            end
            state <= FETCH;
          end else if (branch_taken) begin
            next_pc <= branch_target;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
